// File: rtl/result_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : result_bus_arbiter
// Description : Common-data-bus arbiter for the out-of-order core. Up to
//               PRODUCERS execution units offer tagged results over
//               ready/valid. One result is granted per cycle by round-robin.
//               It is broadcast one cycle later as a registered
//               operand-update strobe that reservation stations snoop.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                      : single clock
//   rst                      : synchronous reset, active low
//   result_valid[i]          : producer i offers a result
//   result_ready[i]          : producer i's result is accepted this cycle
//   result_rs_id[i]          : tag of producer i's result
//   result_value[i]          : value of producer i's result
//   operand_valid            : one-cycle broadcast strobe
//   update_op_rs_id          : broadcast tag (held when no strobe)
//   update_op_value          : broadcast value (held when no strobe)
//   zero_id_error            : pulses when a result tagged 0 was consumed
// ============================================================================
module result_bus_arbiter #(
  parameter int PRODUCERS   = 4,
  parameter int RS_ID_WIDTH = 5,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   result_valid [0:PRODUCERS-1],
  output logic                   result_ready [0:PRODUCERS-1],
  input  logic [RS_ID_WIDTH-1:0] result_rs_id [0:PRODUCERS-1],
  input  logic [DATA_WIDTH-1:0]  result_value [0:PRODUCERS-1],
  output logic                   operand_valid,
  output logic [RS_ID_WIDTH-1:0] update_op_rs_id,
  output logic [DATA_WIDTH-1:0]  update_op_value,
  output logic                   zero_id_error
);

  localparam int c_PTR_W = (PRODUCERS > 1) ? $clog2(PRODUCERS) : 1;
  typedef logic [c_PTR_W-1:0] ptr_t;
  localparam ptr_t c_LAST = ptr_t'(PRODUCERS - 1);

  ptr_t                   r_rr_ptr;
  logic                   r_operand_valid;
  logic [RS_ID_WIDTH-1:0] r_rs_id;
  logic [DATA_WIDTH-1:0]  r_value;
  logic                   r_zero_id_error;

  logic                   w_grant_found;
  ptr_t                   w_grant_idx;
  ptr_t                   w_next_ptr;
  int                     w_idx;
  logic [RS_ID_WIDTH-1:0] w_sel_id;
  logic [DATA_WIDTH-1:0]  w_sel_value;

  // Rotating-priority search: first valid index at or above r_rr_ptr,
  // wrapping past PRODUCERS-1 back to 0.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_idx         = 0;
    for (int k = 0; k < PRODUCERS; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= PRODUCERS) begin
        w_idx = w_idx - PRODUCERS;
      end
      if (!w_grant_found && result_valid[ptr_t'(w_idx)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = ptr_t'(w_idx);
      end
    end
  end

  // Ready is a pure function of valid and pointer, and is held off in reset
  // so nothing can be consumed while the broadcast registers are clearing.
  always_comb begin
    for (int i = 0; i < PRODUCERS; i++) begin
      result_ready[i] = rst & w_grant_found & (w_grant_idx == ptr_t'(i));
    end
  end

  assign w_next_ptr  = (w_grant_idx == c_LAST) ? '0 : ptr_t'(w_grant_idx + 1'b1);
  assign w_sel_id    = result_rs_id[w_grant_idx];
  assign w_sel_value = result_value[w_grant_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr        <= '0;
      r_operand_valid <= 1'b0;
      r_rs_id         <= '0;
      r_value         <= '0;
      r_zero_id_error <= 1'b0;
    end else if (w_grant_found) begin
      r_rr_ptr <= w_next_ptr;
      if (w_sel_id != '0) begin
        r_operand_valid <= 1'b1;
        r_rs_id         <= w_sel_id;
        r_value         <= w_sel_value;
        r_zero_id_error <= 1'b0;
      end else begin
        // Tag 0 means "no dependency": waking anything with it would be
        // wrong, so the result is swallowed and flagged instead.
        r_operand_valid <= 1'b0;
        r_zero_id_error <= 1'b1;
      end
    end else begin
      r_operand_valid <= 1'b0;
      r_zero_id_error <= 1'b0;
    end
  end

  assign operand_valid   = r_operand_valid;
  assign update_op_rs_id = r_rs_id;
  assign update_op_value = r_value;
  assign zero_id_error   = r_zero_id_error;

endmodule
`default_nettype wire
